// File: rtl/fir_frame_buffer.sv
// fir_frame_buffer: ping-pong frame collector between the FIR and FFT stages.
// Packs N samples of W bits into one N*W-bit word under valid/ready.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   in_valid/in_data  FIR sample stream (never stalled)
//   out_valid/out_ready/out_data  frame handshake; slot k at [k*W +: W]
//   overflow        sticky, set when a sample is dropped
//   frame_cnt       frames accepted, wraps
//   wr_bank         bank currently being filled
module fir_frame_buffer #(
  parameter int N      = 16,
  parameter int W      = 16,
  parameter int BITREV = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_data,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             wr_bank
);

  localparam int LG = $clog2(N);

  logic [W-1:0]  mem [2][N];
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          rd_bank;
  logic          rd_n;
  logic [LG-1:0] widx;
  logic [LG-1:0] slot;
  logic          accept;
  logic          wr_free;
  logic          do_wr;
  logic          last;

  function automatic logic [LG-1:0] rev(input logic [LG-1:0] x);
    logic [LG-1:0] r;
    for (int i = 0; i < LG; i++) r[i] = x[LG-1-i];
    return r;
  endfunction

  assign accept = out_valid & out_ready;
  // A bank freed on this edge may be refilled on the same edge.
  assign wr_free = !full[wr_bank] ||
                   (accept && (rd_bank == wr_bank));
  assign do_wr = in_valid & wr_free;
  assign last  = (widx == LG'(N-1));
  assign slot  = (BITREV != 0) ? rev(widx) : widx;
  assign rd_n  = rd_bank ^ accept;

  always_comb begin
    full_n = full;
    if (accept) full_n[rd_bank] = 1'b0;
    if (do_wr && last) full_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      rd_bank   <= 1'b0;
      wr_bank   <= 1'b0;
      widx      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      full      <= full_n;
      rd_bank   <= rd_n;
      // Registered copy of full[rd_bank] using next-state values.
      out_valid <= full_n[rd_n];
      if (accept) frame_cnt <= frame_cnt + CNT_W'(1);
      if (do_wr) begin
        widx <= last ? '0 : widx + LG'(1);
        if (last) wr_bank <= ~wr_bank;
      end
      if (in_valid && !wr_free) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_bank][slot] <= in_data;
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++) out_data[k*W +: W] = mem[rd_bank][k];
    end
  end

endmodule

// File: tb/tb_fir_frame_buffer.sv
// tb_fir_frame_buffer: checks natural and bit-reversed instances
// against a frame-queue reference model.
module tb_fir_frame_buffer;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int CW = 8;
  localparam int LG = $clog2(N);
  localparam int DW = N*W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          ov0, ov1, of0, of1, wb0, wb1;
  logic [DW-1:0] od0, od1;
  logic [CW-1:0] fc0, fc1;

  always #5 clk = ~clk;

  fir_frame_buffer #(.N(N), .W(W), .BITREV(0), .CNT_W(CW)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .overflow(of0), .frame_cnt(fc0), .wr_bank(wb0)
  );

  fir_frame_buffer #(.N(N), .W(W), .BITREV(1), .CNT_W(CW)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .overflow(of1), .frame_cnt(fc1), .wr_bank(wb1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: completed frames waiting in order, plus the one
  // being assembled (stored in arrival order).
  logic [DW-1:0] fq[$];
  logic [DW-1:0] cur;
  int            cur_n;
  int            m_done;
  logic [CW-1:0] m_cnt;
  logic          m_ovf;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] remap(input logic [DW-1:0] f,
                                          input bit br);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int k = 0; k < N; k++) begin
      s = 0;
      for (int b = 0; b < LG; b++)
        if (br ? ((k >> (LG-1-b)) & 1) : ((k >> b) & 1)) s += (1 << b);
      r[k*W +: W] = f[s*W +: W];
    end
    return r;
  endfunction

  task automatic model_reset();
    fq.delete();
    cur = '0;
    cur_n = 0;
    m_done = 0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic iv, input logic [W-1:0] d,
                            input logic rdy);
    if (fq.size() > 0 && rdy) begin
      void'(fq.pop_front());
      m_cnt++;
    end
    if (iv) begin
      if (fq.size() < 2) begin
        cur[cur_n*W +: W] = d;
        cur_n++;
        if (cur_n == N) begin
          fq.push_back(cur);
          cur_n = 0;
          m_done++;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic v;
    logic [DW-1:0] f;
    v = (fq.size() > 0);
    f = v ? fq[0] : '0;
    chk("valid0", DW'(ov0), DW'(v));
    chk("valid1", DW'(ov1), DW'(v));
    chk("data0", od0, remap(f, 1'b0));
    chk("data1", od1, remap(f, 1'b1));
    chk("ovf0", DW'(of0), DW'(m_ovf));
    chk("ovf1", DW'(of1), DW'(m_ovf));
    chk("cnt0", DW'(fc0), DW'(m_cnt));
    chk("cnt1", DW'(fc1), DW'(m_cnt));
    chk("wrbank0", DW'(wb0), DW'(m_done % 2));
    chk("wrbank1", DW'(wb1), DW'(m_done % 2));
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] d,
                       input logic rdy);
    in_valid = iv;
    in_data = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge(iv, d, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    model_reset();
    #2;
    do_reset();

    // 1: single frame, natural and bit-reversed
    for (int i = 0; i < N; i++) cycle(1'b1, W'(i), 1'b1);
    chk("t1_valid", DW'(ov0), DW'(1));
    chk("t1_slot3", DW'(od0[3*W +: W]), DW'(16'h0003));
    chk("t1_slot15", DW'(od0[15*W +: W]), DW'(16'h000F));
    chk("t2_slot1", DW'(od1[1*W +: W]), DW'(16'h0008));
    chk("t2_slot2", DW'(od1[2*W +: W]), DW'(16'h0004));
    chk("t2_slot3", DW'(od1[3*W +: W]), DW'(16'h000C));
    chk("t2_slot15", DW'(od1[15*W +: W]), DW'(16'h000F));
    cycle(1'b0, '0, 1'b1);
    chk("t1_cnt", DW'(fc0), DW'(1));
    chk("t1_gone", DW'(ov0), DW'(0));
    cycle(1'b0, '0, 1'b1);
    chk("t1_ovf", DW'(of0), DW'(0));

    // 3: back-pressure, both banks full, then drops
    do_reset();
    for (int i = 0; i < 3*N; i++) cycle(1'b1, W'(i), 1'b0);
    chk("t3_ovf", DW'(of0), DW'(1));
    chk("t3_hold", DW'(od0[0 +: W]), DW'(16'h0000));
    cycle(1'b0, '0, 1'b1);
    chk("t3_second", DW'(od0[0 +: W]), DW'(16'h0010));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk("t3_cnt", DW'(fc0), DW'(2));

    // 4: accept frees bank 0 on the edge that writes into it
    do_reset();
    for (int i = 0; i < 2*N; i++) cycle(1'b1, W'(i), 1'b0);
    cycle(1'b1, W'(2*N), 1'b1);
    chk("t4_ovf", DW'(of0), DW'(0));
    chk("t4_cnt", DW'(fc0), DW'(1));
    for (int i = 2*N+1; i < 3*N; i++) cycle(1'b1, W'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("t4_slot0", DW'(od0[0 +: W]), DW'(16'h0020));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

    // 5: long stream, random signed data
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      d = (i == 5) ? 16'hFFF9 : W'($urandom);
      cycle(1'b1, d, 1'b1);
      if (i == 15) chk("t5_neg", DW'(od0[5*W +: W]), DW'(16'hFFF9));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk("t5_cnt", DW'(fc0), DW'(64));
    chk("t5_ovf", DW'(of0), DW'(0));

    // 6: reset mid-frame
    for (int i = 0; i < 7; i++) cycle(1'b1, W'(16'h00AA), 1'b0);
    do_reset();
    chk("t6_valid", DW'(ov0), DW'(0));
    for (int i = 0; i < N; i++) cycle(1'b1, W'(16'h0100 + i), 1'b0);
    chk("t6_slot0", DW'(od0[0 +: W]), DW'(16'h0100));
    chk("t6_slot6", DW'(od0[6*W +: W]), DW'(16'h0106));
    cycle(1'b0, '0, 1'b1);

    // random mixed traffic
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 3) == 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_frame_buffer.md
Name: fir_frame_buffer

Overview:
- Sits directly downstream of the FIR stage. Collects its 16-bit filtered sample stream into fixed-length frames for the FFT stage.
- Uses two ping-pong banks, so the FIR output is never stalled while the FFT consumes a frame.
- Each completed frame is presented as one wide parallel word under a valid/ready handshake. Sample order is natural or bit-reversed, selected by parameter.

Parameters:
N, 16, samples per frame; power of two, 4..64
W, 16, sample width in bits
BITREV, 0, 1 = output slot k holds sample bitrev(k); 0 = slot k holds sample k
CNT_W, 8, width of the delivered-frame counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  sample strobe (driven by FIR fir_valid)
in_data  in  W  signed sample (driven by FIR fir_d)
out_valid  out  1  a full frame is presented on out_data
out_ready  in  1  FFT accepts the frame
out_data  out  N*W  frame; slot k occupies bits [k*W +: W]
overflow  out  1  sticky; a sample was dropped
frame_cnt  out  CNT_W  number of frames accepted; wraps modulo 2^CNT_W
wr_bank  out  1  bank currently being filled (debug)

Behaviour:
- Reset (async, rst=1): bank full flags=0, wr_bank=0, rd_bank=0, write index=0, out_valid=0, overflow=0, frame_cnt=0, out_data=0. Bank contents are don't-care; out_data is masked to 0 while out_valid=0.
- Write side:
  - On a rising edge with in_valid=1 and bank[wr_bank] not full, in_data is stored at slot widx of bank[wr_bank].
  - In natural mode the slot is widx. In BITREV mode the slot is bitrev(widx) over log2(N) bits.
  - widx then increments.
- Frame completion:
  - On the write at widx=N-1, set full[wr_bank], reset widx to 0, and toggle wr_bank.
  - No gap is needed: the next in_valid may arrive on the very next cycle and writes the other bank.
- Drop: if in_valid=1 while bank[wr_bank] is full and is not freed on the same edge, the sample is discarded, overflow is set to 1, and widx is unchanged. overflow is cleared only by reset.
- Read side:
  - out_valid = full[rd_bank], registered, so it is a pure flop output.
  - out_data = contents of bank[rd_bank] while out_valid=1.
  - On an edge with out_valid & out_ready: clear full[rd_bank], toggle rd_bank, and increment frame_cnt (wrapping 2^CNT_W-1 -> 0).
  - out_ready while out_valid=0 has no effect.
- Latency: the edge that captures sample N-1 is the edge after which out_valid=1. The frame is visible in the cycle immediately following that edge.
- Ordering: frames are delivered strictly in completion order, and each frame exactly once. out_data remains stable while out_valid=1 and out_ready=0.
- Simultaneous free and write: if an accept frees bank X on the same edge that a sample targets bank X, the free takes priority. The sample is written, not dropped, and overflow stays 0.
- Simultaneous complete and accept: a frame completing into bank X while bank Y is accepted is legal. Both flags update on that edge and out_valid stays 1, now presenting bank X.
- Partial frame: samples remain held indefinitely while in_valid is idle. There is no flush; a trailing partial frame is never delivered.
- Reset mid-frame or mid-handshake: all state returns to reset values at once and partial data is discarded.
- No arithmetic on samples: in_data bits pass through unchanged, including sign.

Test Plan:
1. Reset, then 16 consecutive in_valid samples 0x0000..0x000F with out_ready=1. Required: out_valid high for exactly 1 cycle after the 16th edge; slot k = k; frame_cnt=1; overflow=0.
2. BITREV=1, same stimulus. Required: slot 1=0x0008, slot 2=0x0004, slot 3=0x000C, slot 15=0x000F.
3. out_ready=0, then 48 continuous samples of value i. Required:
   - out_valid=1 after sample 15, with frame 0 held stable.
   - Samples 32..47 dropped and overflow=1.
   - After raising out_ready, frame 0 (0..15) then frame 1 (16..31) are delivered; frame_cnt=2.
4. out_ready=0 through 31 samples. Then out_ready=1 on exactly the edge of sample 32, which targets the full bank 0. Required: sample 32 is stored at slot 0 of bank 0, overflow=0, frame_cnt=1.
5. Continuous stream of 1024 samples with out_ready=1. Required: 64 frames, frame_cnt=64, overflow=0, sign-negative values such as 0xFFF9 reproduced bit-exact.
6. Assert rst after 7 samples of a frame, then send 16 new samples. Required: first delivered frame contains only post-reset data; out_valid=0 during reset.
